sdp_bram_gpm_param: RTL and testbench



---
 rtl/gpm_mem_pkg.sv | 22 ++
 rtl/sdp_bram_core.sv | 40 ++++
 rtl/sdp_bram_gpm_param.sv | 155 +++++++++++++++
 tb/tb_sdp_bram_gpm_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gpm_mem_pkg.sv
// Shared definitions for the GPM storage primitives: controller state
// encoding, lane-count derivation and parameter legality check.
package gpm_mem_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  // Number of independently write-enabled lanes in a word.
  function automatic int nlane(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // True when the width split is exact and the output stage count is legal.
  function automatic bit params_ok(input int data_w, input int lane_w,
                                   input int out_reg);
    return (lane_w > 0) && ((data_w % lane_w) == 0) &&
           ((out_reg == 0) || (out_reg == 1));
  endfunction

endpackage

// File: rtl/sdp_bram_core.sv
// Reset-free simple-dual-port storage array: per-lane synchronous write,
// synchronous (registered) read. Read-during-write to the same address
// returns the old contents; the wrapper resolves that collision.
module sdp_bram_core #(
  parameter int DATA_W = 75,
  parameter int ADDR_W = 10,
  parameter int LANE_W = 75,
  parameter int NLANE  = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NLANE-1:0]  wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_q
);

  localparam int DEPTH = 1 << ADDR_W;

  // NOTE: the array has no reset on purpose; a reset term would stop it
  // mapping onto block RAM. Zeroing is the wrapper's clear engine's job.
  logic [DATA_W-1:0] mem [DEPTH];

  // Per-lane write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NLANE; i++) begin
        if (wr_be[i]) mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
      end
    end
  end

  // Synchronous read port; holds its last word when no read is issued.
  always_ff @(posedge clk) begin
    if (rd_en) rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/sdp_bram_gpm_param.sv
// Parametrised single-clock SDP RAM for the GPM datapath: clear engine,
// write-first collision bypass, aligned read-valid and optional output stage.
module sdp_bram_gpm_param
  import gpm_mem_pkg::*;
#(
  parameter int DATA_W         = 75,
  parameter int ADDR_W         = 10,
  parameter int LANE_W         = 75,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NLANE         = nlane(DATA_W, LANE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NLANE-1:0]  wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clear_req,
  output logic              ready
);

  if (!params_ok(DATA_W, LANE_W, OUT_REG)) begin : g_param_check
    $error("sdp_bram_gpm_param: DATA_W must be a multiple of LANE_W and OUT_REG must be 0 or 1");
  end

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  logic              wr_ok, rd_ok, clearing;
  logic              c_we;
  logic [ADDR_W-1:0] c_waddr;
  logic [NLANE-1:0]  c_wbe;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] rd_q;

  logic              valid1;
  logic              byp_hit;
  logic [NLANE-1:0]  byp_be;
  logic [DATA_W-1:0] byp_data;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] hold_q;

  assign clearing = (state == S_CLEAR);
  assign ready    = (state == S_READY);
  assign wr_ok    = wr_en & ready;
  assign rd_ok    = rd_en & ready;

  // The clear engine owns the write port while active.
  assign c_we    = clearing | wr_ok;
  assign c_waddr = clearing ? cnt : wr_addr;
  assign c_wbe   = clearing ? {NLANE{1'b1}} : wr_be;
  assign c_wdata = clearing ? '0 : wr_data;

  sdp_bram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .LANE_W (LANE_W),
    .NLANE  (NLANE)
  ) u_core (
    .clk     (clk),
    .wr_en   (c_we),
    .wr_addr (c_waddr),
    .wr_be   (c_wbe),
    .wr_data (c_wdata),
    .rd_en   (rd_ok),
    .rd_addr (rd_addr),
    .rd_q    (rd_q)
  );

  // Controller state and clear address counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: sweep every address once, then serve; clear_req restarts a sweep.
  // NOTE: defaults first so no path through the case leaves a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == {ADDR_W{1'b1}}) state_nxt = S_READY;
      end
      S_READY: begin
        cnt_nxt = '0;
        if (clear_req) state_nxt = S_CLEAR;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  // Stage-1 valid plus the collision record for the bypass mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1   <= 1'b0;
      byp_hit  <= 1'b0;
      byp_be   <= '0;
      byp_data <= '0;
    end else begin
      valid1 <= rd_ok;
      if (rd_ok) begin
        byp_hit  <= wr_ok && (wr_addr == rd_addr);
        byp_be   <= wr_be;
        byp_data <= wr_data;
      end
    end
  end

  // Write-first merge: lanes written in the read's cycle take the new data.
  always_comb begin
    merged = rd_q;
    for (int i = 0; i < NLANE; i++) begin
      if (byp_hit && byp_be[i]) merged[i*LANE_W +: LANE_W] = byp_data[i*LANE_W +: LANE_W];
    end
  end

  // Last completed read word; feeds the hold path or the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      hold_q <= '0;
    else if (valid1) hold_q <= merged;
  end

  if (OUT_REG == 0) begin : g_out_direct
    assign rd_data  = valid1 ? merged : hold_q;
    assign rd_valid = valid1;
  end else begin : g_out_reg
    logic valid2;

    // Second valid stage aligned with the registered data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid2 <= 1'b0;
      else        valid2 <= valid1;
    end

    assign rd_data  = hold_q;
    assign rd_valid = valid2;
  end

endmodule

// File: tb/tb_sdp_bram_gpm_param.sv
// Scoreboard bench: two instances (OUT_REG=0 and OUT_REG=1) share stimulus;
// expected words are queued at issue and popped when rd_valid appears.
module tb_sdp_bram_gpm_param;

  localparam int DW = 16;
  localparam int AW = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en, clear_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [1:0]    wr_be;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, ready0, ready1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdp_bram_gpm_param #(
    .DATA_W(DW), .ADDR_W(AW), .LANE_W(8), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .clear_req(clear_req), .ready(ready0)
  );

  sdp_bram_gpm_param #(
    .DATA_W(DW), .ADDR_W(AW), .LANE_W(8), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .clear_req(clear_req), .ready(ready1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pop-and-compare for one instance.
  task automatic mon(input int idx, input logic v, input logic [DW-1:0] d);
    exp_t e;
    if (v) begin
      if (sb[idx].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_valid dut%0d: got rd_valid=1 data=0x%0h, required no valid (cycle %0d)",
                 idx, d, cyc);
      end else begin
        e = sb[idx].pop_front();
        check($sformatf("rd_data dut%0d", idx), 32'(d), 32'(e.data));
        check($sformatf("rd_latency dut%0d", idx), cyc, e.due);
      end
    end else if (sb[idx].size() > 0 && sb[idx][0].due < cyc) begin
      e = sb[idx].pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_rd_valid dut%0d: got no valid at cycle %0d, required data 0x%0h",
               idx, e.due, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, rd_valid0, rd_data0);
      mon(1, rd_valid1, rd_data1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = 2'b00; wr_data = '0;
  endtask

  // Expect a read issued now to complete at t+1 (dut0) and t+2 (dut1).
  task automatic expect_rd(input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.due  = cyc + 1;
    sb[0].push_back(e);
    e.due  = cyc + 2;
    sb[1].push_back(e);
  endtask

  // One clock of stimulus; rd_exp is queued only when the read is to be accepted.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [1:0] be,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                       input logic [DW-1:0] rd_exp);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = ra;
    if (re) expect_rd(rd_exp);
    step();
    idle();
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready0 && n < 64) begin
      step();
      n++;
    end
    check({name, " ready_low_cycles"}, n, 16);
    check({name, " ready dut1"}, 32'(ready1), 1);
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 16; a++) cycle(1'b0, '0, 2'b00, '0, 1'b1, AW'(a), 16'h0000);
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    rst_n = 1'b0;
    repeat (3) step();
    check("reset ready dut0", 32'(ready0), 0);
    check("reset rd_valid dut0", 32'(rd_valid0), 0);
    check("reset rd_data dut0", 32'(rd_data0), 0);
    check("reset rd_valid dut1", 32'(rd_valid1), 0);
    check("reset rd_data dut1", 32'(rd_data1), 0);
    rst_n = 1'b1;

    // Power-up clear then full zero readback.
    wait_ready("post_reset_clear");
    read_all_zero();

    // Simple write then read.
    cycle(1'b1, 4'd3, 2'b11, 16'h1234, 1'b0, '0, '0);
    cycle(1'b0, '0, 2'b00, '0, 1'b1, 4'd3, 16'h1234);

    // Same-cycle collisions, full and partial lane enables.
    cycle(1'b1, 4'd7, 2'b11, 16'h0011, 1'b0, '0, '0);
    cycle(1'b1, 4'd7, 2'b11, 16'h0055, 1'b1, 4'd7, 16'h0055);
    cycle(1'b1, 4'd7, 2'b11, 16'hAB11, 1'b0, '0, '0);
    cycle(1'b1, 4'd7, 2'b01, 16'hCD55, 1'b1, 4'd7, 16'hAB55);
    cycle(1'b0, '0, 2'b00, '0, 1'b1, 4'd7, 16'hAB55);
    cycle(1'b1, 4'd7, 2'b10, 16'h12FF, 1'b1, 4'd7, 16'h1255);
    // Write to a different address in the read's cycle must not bypass.
    cycle(1'b1, 4'd8, 2'b11, 16'hEEEE, 1'b1, 4'd7, 16'h1255);
    repeat (3) step();

    // Streaming reads with a clear request landing mid-stream.
    for (int a = 0; a < 4; a++) cycle(1'b1, AW'(a), 2'b11, 16'h1000 + 16'(a), 1'b0, '0, '0);
    rd_en = 1'b1; rd_addr = 4'd0; expect_rd(16'h1000); step();
    rd_addr = 4'd1; expect_rd(16'h1001); step();
    rd_addr = 4'd2; expect_rd(16'h1002); clear_req = 1'b1; step();
    clear_req = 1'b0;
    check("clear ready_low_at_start", 32'(ready0), 0);
    n = 0;
    while (!ready0 && n < 64) begin
      // Reads and writes (to already-cleared addresses) must all be dropped.
      rd_en = 1'b1; rd_addr = 4'd3;
      wr_en = 1'b1; wr_be = 2'b11; wr_data = 16'hFFFF; wr_addr = AW'(n + 15);
      clear_req = 1'b1;
      step();
      n++;
    end
    idle();
    check("clear_req ready_low_cycles", n, 16);
    read_all_zero();

    // Hold behaviour, then reset in the middle of a clear.
    cycle(1'b1, 4'd9, 2'b11, 16'h5A5A, 1'b0, '0, '0);
    cycle(1'b0, '0, 2'b00, '0, 1'b1, 4'd9, 16'h5A5A);
    repeat (3) step();
    check("hold rd_data dut0", 32'(rd_data0), 32'h5A5A);
    check("hold rd_data dut1", 32'(rd_data1), 32'h5A5A);
    check("hold rd_valid dut0", 32'(rd_valid0), 0);
    clear_req = 1'b1; step(); clear_req = 1'b0;
    repeat (5) step();
    check("mid_clear ready", 32'(ready0), 0);
    check("mid_clear rd_data held", 32'(rd_data0), 32'h5A5A);
    rst_n = 1'b0;
    #1;
    check("async_reset rd_data dut0", 32'(rd_data0), 0);
    check("async_reset rd_data dut1", 32'(rd_data1), 0);
    check("async_reset rd_valid dut0", 32'(rd_valid0), 0);
    check("async_reset ready", 32'(ready0), 0);
    repeat (3) step();
    rst_n = 1'b1;
    wait_ready("restart_after_reset");
    cycle(1'b0, '0, 2'b00, '0, 1'b1, 4'd9, 16'h0000);
    cycle(1'b0, '0, 2'b00, '0, 1'b1, 4'd0, 16'h0000);
    repeat (4) step();

    check("scoreboard drained dut0", 32'(sb[0].size()), 0);
    check("scoreboard drained dut1", 32'(sb[1].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
